// File: rtl/ucsbece152a_counter_ctrl_if.sv
// ----------------------------------------------------------------------------
// ucsbece152a_counter_ctrl_if
//
// Bundles the command handshake and the counter feedback/drive signals of the
// counter sequencer.
//
// Signals:
//   start_i    command strobe
//   stop_i     abort strobe
//   passes_i   number of bounce passes for the next command
//   hold_i     dwell cycles at each endpoint for the next command
//   count_i    feedback from the counter's count_o
//   enable_o   drives the counter's enable_i
//   dir_o      drives the counter's dir_i (0 = up, 1 = down)
//   busy_o     controller is not idle
//   done_o     one-cycle pulse on normal completion
//   pass_cnt_o completed passes of the current or last command
//
// Modports:
//   slave  - the sequencer (consumes commands, produces counter controls)
//   master - the command source / system side
// ----------------------------------------------------------------------------
interface ucsbece152a_counter_ctrl_if #(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4,
    parameter int HOLD_W = 3
);
    logic              start_i;
    logic              stop_i;
    logic [PASS_W-1:0] passes_i;
    logic [HOLD_W-1:0] hold_i;
    logic [WIDTH-1:0]  count_i;
    logic              enable_o;
    logic              dir_o;
    logic              busy_o;
    logic              done_o;
    logic [PASS_W-1:0] pass_cnt_o;

    modport slave (
        input  start_i, stop_i, passes_i, hold_i, count_i,
        output enable_o, dir_o, busy_o, done_o, pass_cnt_o
    );

    modport master (
        output start_i, stop_i, passes_i, hold_i, count_i,
        input  enable_o, dir_o, busy_o, done_o, pass_cnt_o
    );
endinterface

// File: rtl/ucsbece152a_counter_ctrl.sv
// ----------------------------------------------------------------------------
// ucsbece152a_counter_ctrl
//
// Sequencer for the ucsbece152a_counter up/down counter. Each command runs a
// programmed number of bounce passes (0 -> MAX -> 0) with a programmable
// dwell at both endpoints. If the counter is not at 0 when a command starts,
// it is first walked down to 0 (ALIGN). The final pass ends at 0 without a
// bottom dwell.
//
// Ports:
//   clk   rising-edge clock, shared with the counter
//   rst   asynchronous active-low reset (controller only)
//   bus   ucsbece152a_counter_ctrl_if.slave: command handshake, counter
//         enable/direction and count feedback
//
// Parameters WIDTH/PASS_W/HOLD_W must match those of the connected interface
// instance and WIDTH must match the driven counter (WIDTH >= 2).
// ----------------------------------------------------------------------------
module ucsbece152a_counter_ctrl #(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4,
    parameter int HOLD_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    ucsbece152a_counter_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_UP,
        S_HOLD_TOP,
        S_DOWN,
        S_HOLD_BOT,
        S_DONE
    } state_t;

    // The controller reacts one edge early: the counter takes its last step
    // on the same edge the state leaves UP/DOWN/ALIGN, so it never overshoots.
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_TOP_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t            r_state;
    logic [PASS_W-1:0] r_passes;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [PASS_W-1:0] r_pass_cnt;
    logic              r_enable;
    logic              r_dir;
    logic              r_busy;
    logic              r_done;

    state_t            w_next_state;
    logic [PASS_W-1:0] w_pass_inc;
    logic              w_start_acc;
    logic              w_pass_step;
    logic              w_hold_load;
    logic              w_hold_zero;

    assign w_pass_inc  = r_pass_cnt + PASS_W'(1);
    assign w_hold_zero = (r_hold == '0);
    assign w_start_acc = (r_state == S_IDLE) && bus.start_i && !bus.stop_i;
    // A pass completes on the edge the counter steps 1 -> 0 while going down;
    // an abort on that same edge leaves the pass count untouched.
    assign w_pass_step = (r_state == S_DOWN) && (bus.count_i == CNT_ONE) && !bus.stop_i;
    assign w_hold_load = ((w_next_state == S_HOLD_TOP) && (r_state != S_HOLD_TOP)) ||
                         ((w_next_state == S_HOLD_BOT) && (r_state != S_HOLD_BOT));

    always_comb begin
        // NOTE: default assignment first so every path assigns w_next_state
        // and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    if (bus.passes_i == '0)
                        w_next_state = S_DONE;
                    else if (bus.count_i == '0)
                        w_next_state = S_UP;
                    else
                        w_next_state = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (bus.count_i == CNT_ONE)
                    w_next_state = S_UP;
            end
            S_UP: begin
                if (bus.count_i == CNT_TOP_M1)
                    w_next_state = w_hold_zero ? S_DOWN : S_HOLD_TOP;
            end
            S_HOLD_TOP: begin
                if (r_hold_cnt == HOLD_W'(1))
                    w_next_state = S_DOWN;
            end
            S_DOWN: begin
                if (bus.count_i == CNT_ONE) begin
                    if (w_pass_inc == r_passes)
                        w_next_state = S_DONE;
                    else if (w_hold_zero)
                        w_next_state = S_UP;
                    else
                        w_next_state = S_HOLD_BOT;
                end
            end
            S_HOLD_BOT: begin
                if (r_hold_cnt == HOLD_W'(1))
                    w_next_state = S_UP;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        // Abort wins over everything once a command is running.
        if ((r_state != S_IDLE) && bus.stop_i)
            w_next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_passes   <= '0;
            r_hold     <= '0;
            r_hold_cnt <= '0;
            r_pass_cnt <= '0;
            r_enable   <= 1'b0;
            r_dir      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            r_state <= w_next_state;

            if (w_start_acc) begin
                r_passes   <= bus.passes_i;
                r_hold     <= bus.hold_i;
                r_pass_cnt <= '0;
            end else if (w_pass_step) begin
                r_pass_cnt <= w_pass_inc;
            end

            // Dwell counter: loaded with the programmed hold on entry to a
            // dwell state, leaves when it reads 1.
            if (w_hold_load)
                r_hold_cnt <= r_hold;
            else if ((r_state == S_HOLD_TOP) || (r_state == S_HOLD_BOT))
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);

            // Outputs are decoded from the next state and registered, so they
            // are a pure function of the state register in every cycle.
            r_enable <= (w_next_state == S_ALIGN) || (w_next_state == S_UP) ||
                        (w_next_state == S_DOWN);
            r_dir    <= (w_next_state == S_ALIGN) || (w_next_state == S_DOWN);
            r_busy   <= (w_next_state != S_IDLE);
            r_done   <= (w_next_state == S_DONE);
        end
    end

    assign bus.enable_o   = r_enable;
    assign bus.dir_o      = r_dir;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.pass_cnt_o = r_pass_cnt;

endmodule
